// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: sequencer states, exception codes, CP0 register
// addresses, PC-mux select encodings and status/event bit positions.
package cp0_pkg;

  typedef enum logic [1:0] {ST_RUN, ST_TRAP, ST_RET} state_e;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  localparam logic [4:0] C0_STATUS = 5'd12;
  localparam logic [4:0] C0_CAUSE  = 5'd13;
  localparam logic [4:0] C0_EPC    = 5'd14;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_EPC = 2'b10;
  localparam logic [1:0] SEL_VEC = 2'b11;

  localparam int ST_IE      = 0;
  localparam int ST_PIE     = 1;
  localparam int ST_MASK_LO = 8;

  // qualified event vector bit positions, also the mask bit order
  localparam int EV_INT = 0;
  localparam int EV_SYS = 1;
  localparam int EV_RI  = 2;
  localparam int EV_OV  = 3;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority trap encoder: ovf > unimpl > syscall > intr.
module exc_prio_enc
  import cp0_pkg::*;
(
  input  logic [3:0] ev,
  output logic       take,
  output logic [4:0] code,
  output logic       use_pc
);

  always_comb begin
    take   = 1'b1;
    code   = EXC_INT;
    use_pc = 1'b0;
    if (ev[EV_OV]) begin
      code   = EXC_OV;
      use_pc = 1'b1;
    end else if (ev[EV_RI]) begin
      code   = EXC_RI;
      use_pc = 1'b1;
    end else if (ev[EV_SYS]) begin
      code   = EXC_SYS;
    end else if (!ev[EV_INT]) begin
      take   = 1'b0;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: CP0 status/cause/EPC, trap prioritisation
// and registered one-cycle PC redirects with flush.
module exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR  = 32'h0000_0008,
  parameter logic [31:0] EPC_RST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] pc,
  input  logic [31:0] npc,
  input  logic        intr,
  input  logic        syscall,
  input  logic        unimpl,
  input  logic        ovf,
  input  logic        eret,
  input  logic        mtc0,
  input  logic [4:0]  c0_addr,
  input  logic [31:0] c0_wdata,
  output logic [31:0] c0_rdata,
  output logic [1:0]  selpc,
  output logic [31:0] vector,
  output logic [31:0] epc,
  output logic        flush,
  output logic        inta
);

  state_e      state_q, state_d;
  logic        ie_q, ie_d, pie_q, pie_d;
  logic [3:0]  mask_q, mask_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic        pend_q, pend_d;
  logic        inta_q, inta_d;

  logic [3:0]  ev;
  logic        take, use_pc, sync_exc;
  logic [4:0]  take_code;

  // eret masks the interrupt so the return happens first; the still-pending
  // request is taken once IE has been restored.
  always_comb begin
    ev = '0;
    if (state_q == ST_RUN) begin
      ev[EV_OV]  = ovf     & mask_q[EV_OV];
      ev[EV_RI]  = unimpl  & mask_q[EV_RI];
      ev[EV_SYS] = syscall & mask_q[EV_SYS];
      ev[EV_INT] = pend_q & ie_q & mask_q[EV_INT] & ~eret;
    end
  end

  assign sync_exc = |ev[EV_OV:EV_SYS];

  exc_prio_enc u_prio (
    .ev     (ev),
    .take   (take),
    .code   (take_code),
    .use_pc (use_pc)
  );

  always_comb begin
    state_d = ST_RUN;
    ie_d    = ie_q;
    pie_d   = pie_q;
    mask_d  = mask_q;
    code_d  = code_q;
    epc_d   = epc_q;
    inta_d  = 1'b0;
    pend_d  = intr | (pend_q & ~inta_q);
    if (state_q == ST_RUN) begin
      if (mtc0 && !sync_exc) begin
        case (c0_addr)
          C0_STATUS: begin
            ie_d   = c0_wdata[ST_IE];
            pie_d  = c0_wdata[ST_PIE];
            mask_d = c0_wdata[ST_MASK_LO+3:ST_MASK_LO];
          end
          C0_CAUSE: code_d = c0_wdata[6:2];
          C0_EPC:   epc_d  = c0_wdata;
          default: ;
        endcase
      end
      // trap fields override a same-cycle CP0 write
      if (take) begin
        state_d = ST_TRAP;
        code_d  = take_code;
        pie_d   = ie_q;
        ie_d    = 1'b0;
        epc_d   = use_pc ? pc : npc;
        inta_d  = ~sync_exc;
      end else if (eret) begin
        state_d = ST_RET;
        ie_d    = pie_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= ST_RUN;
      ie_q    <= 1'b0;
      pie_q   <= 1'b0;
      mask_q  <= '0;
      code_q  <= '0;
      epc_q   <= EPC_RST;
      pend_q  <= 1'b0;
      inta_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      pie_q   <= pie_d;
      mask_q  <= mask_d;
      code_q  <= code_d;
      epc_q   <= epc_d;
      pend_q  <= pend_d;
      inta_q  <= inta_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_TRAP: selpc = SEL_VEC;
      ST_RET:  selpc = SEL_EPC;
      default: selpc = SEL_SEQ;
    endcase
  end

  always_comb begin
    case (c0_addr)
      C0_STATUS: c0_rdata = {20'b0, mask_q, 6'b0, pie_q, ie_q};
      C0_CAUSE:  c0_rdata = {25'b0, code_q, 2'b0};
      C0_EPC:    c0_rdata = epc_q;
      default:   c0_rdata = '0;
    endcase
  end

  assign flush  = (state_q != ST_RUN);
  assign inta   = inta_q;
  assign epc    = epc_q;
  assign vector = VECTOR;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: a behavioural CP0 model predicts each
// cycle's outputs, which are queued and compared after the clock edge.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic [31:0] pc, npc, c0_wdata;
  logic        intr, syscall, unimpl, ovf, eret, mtc0;
  logic [4:0]  c0_addr;
  logic [31:0] c0_rdata, vector, epc;
  logic [1:0]  selpc;
  logic        flush, inta;

  exc_ctrl dut (
    .clk(clk), .clrn(clrn), .pc(pc), .npc(npc), .intr(intr),
    .syscall(syscall), .unimpl(unimpl), .ovf(ovf), .eret(eret),
    .mtc0(mtc0), .c0_addr(c0_addr), .c0_wdata(c0_wdata),
    .c0_rdata(c0_rdata), .selpc(selpc), .vector(vector), .epc(epc),
    .flush(flush), .inta(inta)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  selpc;
    logic        flush;
    logic        inta;
    logic [31:0] epc;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // reference model: 0 run, 1 trap, 2 return
  int        m_state;
  bit        m_ie, m_pie, m_pend, m_inta;
  bit [3:0]  m_mask;
  bit [4:0]  m_code;
  bit [31:0] m_epc;

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd12:   return {20'b0, m_mask, 6'b0, m_pie, m_ie};
      5'd13:   return {25'b0, m_code, 2'b0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit        t_sync, t_int, n_ie, n_pie, n_pend;
    bit [3:0]  n_mask;
    bit [4:0]  n_code, c;
    bit [31:0] n_epc, e;
    int        n_state;
    if (!clrn) begin
      m_state = 0; m_ie = 0; m_pie = 0; m_pend = 0; m_inta = 0;
      m_mask = 0; m_code = 0; m_epc = 32'h0;
      return;
    end
    t_sync = 0; t_int = 0; c = 0; e = 0;
    n_ie = m_ie; n_pie = m_pie; n_mask = m_mask; n_code = m_code; n_epc = m_epc;
    n_pend = intr || (m_pend && !m_inta);
    n_state = 0;
    if (m_state == 0) begin
      if (ovf && m_mask[3])          begin t_sync = 1; c = 12; e = pc;  end
      else if (unimpl && m_mask[2])  begin t_sync = 1; c = 10; e = pc;  end
      else if (syscall && m_mask[1]) begin t_sync = 1; c = 8;  e = npc; end
      else if (!eret && m_pend && m_ie && m_mask[0]) begin t_int = 1; c = 0; e = npc; end
      if (mtc0 && !t_sync) begin
        if (c0_addr == 12) begin
          n_ie = c0_wdata[0]; n_pie = c0_wdata[1]; n_mask = c0_wdata[11:8];
        end else if (c0_addr == 13) n_code = c0_wdata[6:2];
        else if (c0_addr == 14) n_epc = c0_wdata;
      end
      if (t_sync || t_int) begin
        n_state = 1; n_code = c; n_pie = m_ie; n_ie = 0; n_epc = e;
      end else if (eret) begin
        n_state = 2; n_ie = m_pie;
      end
    end
    m_state = n_state; m_ie = n_ie; m_pie = n_pie; m_mask = n_mask;
    m_code = n_code; m_epc = n_epc; m_pend = n_pend; m_inta = t_int;
  endtask

  task automatic clr_in();
    pc = 32'h0; npc = 32'h4; intr = 0; syscall = 0; unimpl = 0; ovf = 0;
    eret = 0; mtc0 = 0; c0_addr = 5'd12; c0_wdata = 32'h0;
  endtask

  // one clock: predict, push, clock, pop and compare
  task automatic cyc();
    exp_t x, y;
    model_step();
    x.selpc = (m_state == 1) ? 2'b11 : (m_state == 2) ? 2'b10 : 2'b00;
    x.flush = (m_state != 0);
    x.inta  = m_inta;
    x.epc   = m_epc;
    x.rdata = m_read(c0_addr);
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk("selpc", {30'b0, selpc}, {30'b0, y.selpc});
    chk("flush", {31'b0, flush}, {31'b0, y.flush});
    chk("inta",  {31'b0, inta},  {31'b0, y.inta});
    chk("epc",   epc, y.epc);
    chk("rdata", c0_rdata, y.rdata);
    @(negedge clk);
  endtask

  initial begin
    clr_in();
    clrn = 0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_status", c0_rdata, 32'h0);
    chk("vector", vector, 32'h8);
    clrn = 1;
    cyc();
    intr = 1; cyc();                 // IE=0: only latches pend
    chk("no_int_trap", {30'b0, selpc}, 32'h0);
    intr = 0; cyc();
    cyc();
    chk("idle_selpc", {30'b0, selpc}, 32'h0);

    mtc0 = 1; c0_addr = 5'd12; c0_wdata = 32'h0F01; cyc();
    clr_in(); ovf = 1; pc = 32'h40; npc = 32'h44; c0_addr = 5'd13; cyc();
    chk("ovf_selpc", {30'b0, selpc}, 32'h3);
    chk("ovf_cause", c0_rdata, 32'h30);
    chk("ovf_epc", epc, 32'h40);
    clr_in(); mtc0 = 1; c0_addr = 5'd12; c0_wdata = 32'h0; cyc();  // ignored in TRAP
    chk("trap_status", c0_rdata, 32'h0F02);
    clr_in(); cyc();                 // pend=1 but IE=0
    eret = 1; cyc();
    chk("ret_selpc", {30'b0, selpc}, 32'h2);
    chk("ret_epc", epc, 32'h40);
    eret = 0; npc = 32'h84; intr = 1; cyc();
    cyc();                           // pending interrupt taken
    chk("int_inta", {31'b0, inta}, 32'h1);
    chk("int_epc", epc, 32'h84);
    c0_addr = 5'd13; cyc(); cyc(); cyc();
    chk("int_hold", {30'b0, selpc}, 32'h0);
    eret = 1; cyc(); eret = 0; cyc(); cyc(); cyc();
    intr = 0; cyc(); cyc();

    clr_in(); mtc0 = 1; c0_addr = 5'd12; c0_wdata = 32'h0F01; cyc();
    clr_in(); ovf = 1; syscall = 1; intr = 1; pc = 32'h100; npc = 32'h104;
    c0_addr = 5'd13; cyc();
    chk("combo_cause", c0_rdata, 32'h30);
    ovf = 0; cyc();
    syscall = 0; intr = 0; cyc();
    eret = 1; cyc(); eret = 0; cyc(); npc = 32'h200; cyc(); cyc(); cyc();

    clr_in(); mtc0 = 1; c0_addr = 5'd12; c0_wdata = 32'h0F01; cyc();
    clr_in(); ovf = 1; pc = 32'h300; cyc();
    ovf = 0; clrn = 0; c0_addr = 5'd14; cyc();
    chk("rst_trap_selpc", {30'b0, selpc}, 32'h0);
    chk("rst_trap_epc", epc, 32'h0);
    clrn = 1; cyc();

    for (int i = 0; i < 300; i++) begin
      pc       = $urandom & 32'hFFFF_FFFC;
      npc      = pc + 4;
      intr     = ($urandom_range(0, 3) == 0);
      syscall  = ($urandom_range(0, 7) == 0);
      unimpl   = ($urandom_range(0, 9) == 0);
      ovf      = ($urandom_range(0, 9) == 0);
      eret     = ($urandom_range(0, 7) == 0);
      mtc0     = ($urandom_range(0, 5) == 0);
      c0_addr  = 5'($urandom_range(11, 15));
      c0_wdata = $urandom;
      clrn     = ($urandom_range(0, 60) != 0);
      cyc();
    end
    clrn = 1; clr_in(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/interrupt sequencer for the CPU datapath. Owns the coprocessor-0 state (status, cause, EPC), detects and prioritises trap events, and drives the 2-bit next-PC source select of the 3-input 32-bit PC multiplexer: 00/01 sequential, 10 EPC, 11 vector. Redirects are registered, so every redirect is one clean cycle with a pipeline flush.

## Interface
Parameters:
- VECTOR, 32'h0000_0008, exception handler entry address driven on `vector`
- EPC_RST, 32'h0000_0000, reset value of EPC

Ports:
- clk  in  1  clock, rising edge
- clrn  in  1  reset; one clock, reset is synchronous and active-low
- pc  in  32  address of the instruction currently committing
- npc  in  32  address of the following instruction (pc+4 or branch target)
- intr  in  1  external interrupt request, level
- syscall / unimpl / ovf  in  1 each  synchronous exception flags for the instruction at `pc`
- eret  in  1  return-from-exception is committing
- mtc0  in  1  CP0 write enable
- c0_addr  in  5  CP0 register address (12 status, 13 cause, 14 epc)
- c0_wdata  in  32  CP0 write data
- c0_rdata  out  32  CP0 read data, combinational on `c0_addr`; unmapped addresses read 0
- selpc  out  2  PC mux select
- vector  out  32  constant VECTOR
- epc  out  32  EPC register
- flush  out  1  kill the instruction fetched in the redirect cycle
- inta  out  1  one-cycle interrupt acknowledge

## Operation
- FSM states: RUN, TRAP, RET. Reset -> RUN.
- status: bit0 IE, bit1 PIE, bits[11:8] mask {ovf, unimpl, syscall, intr}; other bits write-ignored, read 0. cause[6:2] ExcCode: intr 0, syscall 8, unimpl 10, ovf 12; other bits 0.
- `pend` flag: set on any cycle with intr=1; cleared in the cycle inta=1.
- An event qualifies in RUN only: ovf/unimpl/syscall if its mask bit is set; intr if pend=1, IE=1 and mask[8]=1.
- Priority: ovf > unimpl > syscall > intr. Exactly one is taken.
- On a taken event at edge: state<=TRAP; cause[6:2]<=code; PIE<=IE; IE<=0; epc<=pc for ovf/unimpl, npc for syscall/intr; for intr, inta=1 in the following cycle.
- eret in RUN with no taken event: state<=RET; IE<=PIE.
- eret together with a synchronous exception: exception wins. eret together with intr: eret wins; the interrupt is taken after return when IE is restored.
- mtc0 write: applied in RUN when no synchronous exception is taken; with a taken interrupt the write applies first, then the trap updates IE/PIE/cause/epc on top of it. The write is ignored in TRAP/RET.
- TRAP: selpc=11, flush=1, then RUN. RET: selpc=10, flush=1, then RUN. All event inputs are ignored in TRAP/RET; pend persists.
- In RUN: selpc=00, flush=0.

## Timing
- Reset values: selpc=00, flush=0, inta=0, epc=EPC_RST, status=0 (all disabled), cause=0, pend=0, state RUN. c0_rdata follows the reset registers.
- Latency: an event sampled at edge N gives selpc/flush/inta at N..N+1 (one cycle after sampling) and selpc=00 again after edge N+1.
- Minimum spacing between redirects is 2 cycles. Back-to-back events are served by priority, one per RUN cycle.
- Reset mid-TRAP/RET returns to RUN at the next edge and drops the redirect.

## Structure
- Shared package `cp0_pkg`: state enum, ExcCode constants, CP0 address constants (12/13/14), selpc encodings (SEL_SEQ=00, SEL_EPC=10, SEL_VEC=11), status bit indices.
- One sub-module: `exc_prio_enc`. It takes the qualified event vector and outputs take, ExcCode, and the use_pc/use_npc choice. It is purely combinational.

## Test plan
- Reset, then idle: selpc=00, flush=0, status=0, epc=0; intr=1 is not taken (IE=0), and pend becomes 1.
- mtc0 status=0x0F01, ovf=1 with pc=0x40: next cycle selpc=11, flush=1; epc=0x40, cause=0x30, IE=0, PIE=1.
- IE on, intr=1 with npc=0x84: inta pulses once, epc=0x84, cause=0; with intr still high there is no second trap until eret.
- eret in RUN: next cycle selpc=10, flush=1, epc driven unchanged, IE restored from PIE; the pending intr is taken in the cycle after RUN resumes.
- ovf, syscall and intr asserted together: ovf taken (code 12); syscall is ignored because it was flushed; intr is taken after eret.
- clrn=0 during TRAP: the next cycle shows selpc=00, flush=0, all CP0 registers at reset values.
